// File: rtl/uart_rx_basic.sv
// 8N1 UART receiver, LSB first, with mid-bit sampling and a one-entry valid/ready
// holding register that reports framing errors and overruns as one-cycle pulses.
module uart_rx_basic #(
  parameter int CLK_FREQ  = 50000000,
  parameter int BAUD_RATE = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       data_valid,
  input  logic       data_ready,
  output logic       busy,
  output logic       frame_err,
  output logic       overrun
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  generate
    if (CLKS_PER_BIT < 4) begin : g_bad_rate
      $error("uart_rx_basic: CLK_FREQ/BAUD_RATE must be at least 4");
    end
  endgenerate

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } state_t;

  state_t           state;
  logic             rx_p0;
  logic             rx_s;
  logic [CNT_W-1:0] clk_counter;
  logic [2:0]       bit_index;
  logic [7:0]       shift_reg;

  // Stage p0 -> rx_s: two-flop synchroniser, idles high so reset never looks like a start bit
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_p0 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      rx_p0 <= rx;
      rx_s  <= rx_p0;
    end
  end

  // Frame FSM, bit timer and holding register share one register block
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      clk_counter <= '0;
      bit_index   <= '0;
      shift_reg   <= '0;
      data_out    <= '0;
      data_valid  <= 1'b0;
      busy        <= 1'b0;
      frame_err   <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      if (data_valid && data_ready) begin
        data_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (!rx_s) begin
            state       <= START;
            busy        <= 1'b1;
            clk_counter <= '0;
          end else begin
            clk_counter <= clk_counter + CNT_W'(1);
          end
        end

        START: begin
          if (clk_counter == CNT_HALF) begin
            clk_counter <= '0;
            bit_index   <= '0;
            if (!rx_s) begin
              state <= DATA;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            clk_counter <= clk_counter + CNT_W'(1);
          end
        end

        DATA: begin
          if (clk_counter == CNT_LAST) begin
            clk_counter            <= '0;
            shift_reg[bit_index]   <= rx_s;
            if (bit_index == 3'd7) begin
              state <= STOP;
            end else begin
              bit_index <= bit_index + 3'd1;
            end
          end else begin
            clk_counter <= clk_counter + CNT_W'(1);
          end
        end

        STOP: begin
          if (clk_counter == CNT_LAST) begin
            clk_counter <= '0;
            if (rx_s) begin
              state <= IDLE;
              busy  <= 1'b0;
              // A byte leaving the holding register this cycle frees the slot for the new one
              if (!data_valid || data_ready) begin
                data_out   <= shift_reg;
                data_valid <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
            end else begin
              state     <= WAIT_IDLE;
              frame_err <= 1'b1;
            end
          end else begin
            clk_counter <= clk_counter + CNT_W'(1);
          end
        end

        WAIT_IDLE: begin
          if (rx_s) begin
            state       <= IDLE;
            busy        <= 1'b0;
            clk_counter <= '0;
          end else begin
            clk_counter <= clk_counter + CNT_W'(1);
          end
        end

        default: begin
          state       <= IDLE;
          busy        <= 1'b0;
          clk_counter <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_basic.sv
// Directed bench for uart_rx_basic at 16 clocks per bit; received bytes are checked
// against a scoreboard queue filled as frames are driven.
module tb_uart_rx_basic;

  localparam int CPB      = 16;
  localparam int HALF_BIT = CPB / 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b1;
  logic       data_ready = 1'b0;
  logic [7:0] data_out;
  logic       data_valid;
  logic       busy;
  logic       frame_err;
  logic       overrun;

  uart_rx_basic #(
    .CLK_FREQ (1600000),
    .BAUD_RATE(100000)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .data_out  (data_out),
    .data_valid(data_valid),
    .data_ready(data_ready),
    .busy      (busy),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int acc_cnt = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  int rise_cyc = 0;
  int start_cyc = 0;
  logic busy_seen = 1'b0;
  logic pv = 1'b0;
  logic pr = 1'b0;
  logic [7:0] pd = 8'h00;
  logic [7:0] sb_q[$];

  initial forever #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called just after a rising edge; leaves rx at the stop-bit level on return.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    start_cyc = cyc;
    rx = 1'b0;
    repeat (CPB) @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(posedge clk);
      #1;
    end
    rx = stop_bit;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic idle_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Output monitor: handshake, hold stability, flag exclusivity and scoreboard compare
  initial forever begin
    @(negedge clk);
    if (rst) begin
      pv = 1'b0;
      pr = 1'b0;
    end else begin
      if (pv && !pr) begin
        chk("hold_valid", 32'(data_valid), 32'd1);
        chk("hold_data", 32'(data_out), 32'(pd));
      end
      if (data_valid && !pv) rise_cyc = cyc;
      if (data_valid && data_ready) begin
        acc_cnt++;
        if (sb_q.size() == 0) begin
          chk("sb_pending", 32'(sb_q.size()), 32'd1);
        end else begin
          chk("rx_byte", 32'(data_out), 32'(sb_q[0]));
          void'(sb_q.pop_front());
        end
      end
      if (frame_err) fe_cnt++;
      if (overrun) ov_cnt++;
      if (frame_err || overrun) chk("flag_excl", 32'(frame_err && overrun), 32'd0);
      if (busy) busy_seen = 1'b1;
      pv = data_valid;
      pr = data_ready;
      pd = data_out;
    end
  end

  initial begin
    int a0, f0, o0, n, lat;

    // Reset state
    rst = 1'b1;
    idle_clks(3);
    chk("rst_data_out", 32'(data_out), 32'h00);
    chk("rst_data_valid", 32'(data_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_flags", 32'({frame_err, overrun}), 32'd0);
    rst = 1'b0;
    data_ready = 1'b1;
    idle_clks(5);

    // 1: single byte, latency and busy
    a0 = acc_cnt; f0 = fe_cnt; o0 = ov_cnt;
    sb_q.push_back(8'hA5);
    fork
      send_frame(8'hA5, 1'b1);
      begin
        idle_clks(80);
        chk("t1_busy_mid", 32'(busy), 32'd1);
      end
    join
    idle_clks(5);
    lat = rise_cyc - start_cyc;
    chk("t1_count", 32'(acc_cnt - a0), 32'd1);
    chk("t1_latency_ok", 32'(lat >= 154 && lat <= 156), 32'd1);
    chk("t1_valid_low", 32'(data_valid), 32'd0);
    chk("t1_busy_idle", 32'(busy), 32'd0);
    chk("t1_flags", 32'((fe_cnt - f0) + (ov_cnt - o0)), 32'd0);

    // 2: back-to-back 0x00, 0xFF
    a0 = acc_cnt; f0 = fe_cnt; o0 = ov_cnt;
    sb_q.push_back(8'h00);
    sb_q.push_back(8'hFF);
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    idle_clks(5);
    chk("t2_count", 32'(acc_cnt - a0), 32'd2);
    chk("t2_sb_empty", 32'(sb_q.size()), 32'd0);
    chk("t2_flags", 32'((fe_cnt - f0) + (ov_cnt - o0)), 32'd0);

    // 3: start-bit glitch
    a0 = acc_cnt; f0 = fe_cnt; o0 = ov_cnt;
    busy_seen = 1'b0;
    rx = 1'b0;
    idle_clks(5);
    rx = 1'b1;
    n = 0;
    while (busy && n < 40) begin
      idle_clks(1);
      n++;
    end
    chk("t3_busy_seen", 32'(busy_seen), 32'd1);
    chk("t3_busy_clear_in_time", 32'(n <= HALF_BIT + 3), 32'd1);
    idle_clks(30);
    chk("t3_no_byte", 32'(acc_cnt - a0), 32'd0);
    chk("t3_flags", 32'((fe_cnt - f0) + (ov_cnt - o0)), 32'd0);

    // 4: framing error, line held low, then recovery
    a0 = acc_cnt; f0 = fe_cnt; o0 = ov_cnt;
    send_frame(8'h3C, 1'b0);
    idle_clks(40);
    chk("t4_wait_idle_busy", 32'(busy), 32'd1);
    chk("t4_frame_err_once", 32'(fe_cnt - f0), 32'd1);
    chk("t4_no_byte", 32'(acc_cnt - a0), 32'd0);
    rx = 1'b1;
    idle_clks(5);
    chk("t4_busy_release", 32'(busy), 32'd0);
    sb_q.push_back(8'h55);
    send_frame(8'h55, 1'b1);
    idle_clks(5);
    chk("t4_recover_count", 32'(acc_cnt - a0), 32'd1);
    chk("t4_fe_total", 32'(fe_cnt - f0), 32'd1);
    chk("t4_no_overrun", 32'(ov_cnt - o0), 32'd0);

    // 5a: overrun with consumer stalled
    data_ready = 1'b0;
    a0 = acc_cnt; f0 = fe_cnt; o0 = ov_cnt;
    sb_q.push_back(8'h11);
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    idle_clks(5);
    chk("t5_valid_held", 32'(data_valid), 32'd1);
    chk("t5_data_held", 32'(data_out), 32'h11);
    chk("t5_overrun_once", 32'(ov_cnt - o0), 32'd1);
    chk("t5_no_accept", 32'(acc_cnt - a0), 32'd0);
    data_ready = 1'b1;
    idle_clks(3);
    data_ready = 1'b0;
    chk("t5_drain_count", 32'(acc_cnt - a0), 32'd1);
    chk("t5_drain_valid", 32'(data_valid), 32'd0);
    chk("t5_no_fe", 32'(fe_cnt - f0), 32'd0);

    // 5b: consumer accepts on the exact completion edge
    a0 = acc_cnt; o0 = ov_cnt;
    sb_q.push_back(8'h11);
    send_frame(8'h11, 1'b1);
    sb_q.push_back(8'h22);
    fork
      send_frame(8'h22, 1'b1);
      begin
        idle_clks(154);
        data_ready = 1'b1;
        idle_clks(2);
        data_ready = 1'b0;
      end
    join
    idle_clks(5);
    chk("t5b_no_overrun", 32'(ov_cnt - o0), 32'd0);
    chk("t5b_count", 32'(acc_cnt - a0), 32'd2);
    chk("t5b_data", 32'(data_out), 32'h22);
    chk("t5b_sb_empty", 32'(sb_q.size()), 32'd0);

    // 6: reset in the middle of a frame, then a clean frame
    data_ready = 1'b1;
    fork
      send_frame(8'h96, 1'b1);
      begin
        idle_clks(130);
        chk("t6_busy_pre", 32'(busy), 32'd1);
        rst = 1'b1;
        idle_clks(1);
        chk("t6_rst_data_out", 32'(data_out), 32'h00);
        chk("t6_rst_valid", 32'(data_valid), 32'd0);
        chk("t6_rst_busy", 32'(busy), 32'd0);
        chk("t6_rst_flags", 32'({frame_err, overrun}), 32'd0);
        rst = 1'b0;
      end
    join
    idle_clks(20);
    a0 = acc_cnt; f0 = fe_cnt; o0 = ov_cnt;
    sb_q.push_back(8'h69);
    send_frame(8'h69, 1'b1);
    idle_clks(5);
    chk("t6_count", 32'(acc_cnt - a0), 32'd1);
    chk("t6_flags", 32'((fe_cnt - f0) + (ov_cnt - o0)), 32'd0);
    chk("final_sb_empty", 32'(sb_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx_basic.md
Name: uart_rx_basic

Overview:
- UART receiver, 8N1, LSB first. Receive-side counterpart of the block's uart_tx_basic transmitter; same CLK_FREQ/BAUD_RATE parameterisation, so a TX/RX pair interoperates unchanged.
- Synchronises the asynchronous rx line, detects and qualifies the start bit, and samples each bit at mid-bit.
- Hands received bytes to the core through a one-entry valid/ready holding register, with framing-error and overrun flags.

Parameters:
- CLK_FREQ, default 50000000: clock frequency in Hz.
- BAUD_RATE, default 115200: baud rate.
- Derived CLKS_PER_BIT = CLK_FREQ / BAUD_RATE (integer division; 434 at defaults). It must be >= 4; elaboration fails otherwise.
- Derived HALF_BIT = CLKS_PER_BIT / 2.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous reset, active-high.
- rx  input  1  serial line, asynchronous, idle high.
- data_out  output  8  received byte; stable while data_valid is high.
- data_valid  output  1  byte available in the holding register.
- data_ready  input  1  consumer accepts the byte when data_valid && data_ready.
- busy  output  1  a frame is in progress (state != IDLE).
- frame_err  output  1  one-cycle pulse: stop bit sampled low.
- overrun  output  1  one-cycle pulse: a completed byte was dropped because the holding register was full.

Behaviour:
- Reset:
  - rst is sampled on a rising clk edge.
  - Reset values: data_out=0, data_valid=0, busy=0, frame_err=0, overrun=0, state=IDLE, counters=0.
  - Both synchroniser flops reset to 1, so no false start is seen after reset.
  - Reset mid-frame abandons the frame; no flag is raised.
- Synchroniser: two flops on rx produce rx_s. All decisions use rx_s only.
- Bit timer:
  - clk_counter width $clog2(CLKS_PER_BIT).
  - Cleared on every state change; increments otherwise.
- State machine:
  - IDLE:
    - busy=0.
    - On rx_s==0, go to START.
  - START:
    - When clk_counter == HALF_BIT-1, sample rx_s.
    - If rx_s==0: go to DATA with bit_index=0.
    - If rx_s==1: glitch; return to IDLE, no flag.
  - DATA:
    - When clk_counter == CLKS_PER_BIT-1, shift rx_s into shift_reg[bit_index] (bit 0 first).
    - After bit 7, go to STOP; otherwise bit_index+1.
  - STOP:
    - When clk_counter == CLKS_PER_BIT-1, sample rx_s.
    - If 1: complete the byte and go to IDLE.
    - If 0: pulse frame_err, discard the byte, go to WAIT_IDLE.
  - WAIT_IDLE:
    - Stay until rx_s==1, then go to IDLE. This prevents a break or stuck-low line from retriggering.
    - busy=1 in this state.
- Byte completion (same edge the stop bit is sampled high):
  - Holding register empty, or data_valid && data_ready in that cycle: data_out <= shift_reg and data_valid <= 1 on the next edge.
  - Holding register full and data_ready low: overrun pulses for one cycle; the old byte and data_valid are kept; the new byte is dropped.
- Handshake:
  - data_valid clears on the edge where data_valid && data_ready, unless a completion lands on that same edge, in which case it stays 1 with the new data.
  - data_out never changes while data_valid=1 and data_ready=0.
- Latency: from the rx falling edge at the pin to data_valid high is 2 (sync) + HALF_BIT + 9*CLKS_PER_BIT + 1 clocks, ±1.
- frame_err and overrun are never asserted in the same cycle. Neither flag is sticky.

Test Plan:
Common setup: CLK_FREQ=1600000, BAUD_RATE=100000 (CLKS_PER_BIT=16), TX frames driven at exactly 16 clk/bit.
1. Send 0xA5, data_ready=1 -> data_valid high for one cycle with data_out=0xA5 about 155 clocks after the start edge; frame_err=0, overrun=0; busy high during the frame.
2. Send 0x00 then 0xFF back-to-back, data_ready=1 -> two valid bytes 0x00, 0xFF in order; no flags.
3. Pulse rx low for 5 clocks, then return high -> no data_valid, busy returns to 0 within HALF_BIT+3 clocks, no flags.
4. Send 0x3C with stop bit forced low, then hold rx low for 40 clocks -> frame_err one pulse, no data_valid, state stays WAIT_IDLE until rx high. A following 0x55 is received correctly.
5. data_ready=0; send 0x11 then 0x22 -> data_valid=1 with data_out=0x11, overrun pulses once at the 0x22 stop. Raising data_ready yields 0x11 only. Separately, assert data_ready exactly on the 0x22 completion cycle -> no overrun, data_out=0x22.
6. Assert rst for 1 cycle mid-DATA of 0x96 -> all outputs return to reset values next edge. The next full frame 0x69 is received correctly.
